// File: rtl/hht_mem_responder.sv
// Memory-side responder for the HHT control block: two windowed read ports with fixed latency and a preload write port.
// Optional HHT_MEM_WR_FWD_EN: same-cycle write data is forwarded to a read of the same word (write-first).
module hht_mem_responder #(
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 32,
    parameter int                COL_DEPTH = 128,
    parameter int                V_DEPTH   = 16,
    parameter int                RD_LAT    = 1,
    parameter logic [DATA_W-1:0] SENTINEL  = DATA_W'(99999)
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              cfg_load,
    input  logic [ADDR_W-1:0] col_base_in,
    input  logic [ADDR_W-1:0] v_base_in,
    input  logic              WR,
    input  logic              wr_sel,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              RD,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [ADDR_W-1:0] addr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    output logic              rvalid,
    output logic              oor_err,
    output logic [15:0]       rd_count
);

    localparam int              CIDX_W   = $clog2(COL_DEPTH);
    localparam int              VIDX_W   = $clog2(V_DEPTH);
    localparam logic [ADDR_W:0] COL_SPAN = (ADDR_W+1)'(COL_DEPTH);
    localparam logic [ADDR_W:0] V_SPAN   = (ADDR_W+1)'(V_DEPTH);

    // Bounds are widened by one bit so a window near the top of the address space never wraps to low addresses.
    function automatic logic in_window(input logic [ADDR_W-1:0] addr,
                                       input logic [ADDR_W-1:0] base,
                                       input logic [ADDR_W:0]   span);
        logic [ADDR_W:0] lo;
        logic [ADDR_W:0] hi;
        logic [ADDR_W:0] a_ext;
        lo    = {1'b0, base};
        hi    = lo + span - (ADDR_W+1)'(1);
        a_ext = {1'b0, addr};
        return (a_ext >= lo) && (a_ext <= hi);
    endfunction

    logic [DATA_W-1:0] col_mem [COL_DEPTH];
    logic [DATA_W-1:0] v_mem   [V_DEPTH];

    logic [ADDR_W-1:0] col_base_q, col_base_d;
    logic [ADDR_W-1:0] v_base_q, v_base_d;
    logic              oor_err_q, oor_err_d;
    logic [15:0]       rd_count_q, rd_count_d;

    logic [RD_LAT-1:0]             pv_q, pv_d;
    logic [RD_LAT-1:0][DATA_W-1:0] pd1_q, pd1_d;
    logic [RD_LAT-1:0][DATA_W-1:0] pd2_q, pd2_d;

    logic              hit1, hit2;
    logic [CIDX_W-1:0] idx1, wr_col_idx;
    logic [VIDX_W-1:0] idx2, wr_v_idx;
    logic              wr_col_hit, wr_v_hit;
    logic              fwd1, fwd2;
    logic [DATA_W-1:0] word1, word2;

    always_comb begin
        hit1       = in_window(addr1, col_base_q, COL_SPAN);
        hit2       = in_window(addr2, v_base_q, V_SPAN);
        idx1       = CIDX_W'(addr1 - col_base_q);
        idx2       = VIDX_W'(addr2 - v_base_q);
        wr_col_idx = CIDX_W'(wr_addr - col_base_q);
        wr_v_idx   = VIDX_W'(wr_addr - v_base_q);
        wr_col_hit = WR && !wr_sel && in_window(wr_addr, col_base_q, COL_SPAN);
        wr_v_hit   = WR &&  wr_sel && in_window(wr_addr, v_base_q, V_SPAN);
`ifdef HHT_MEM_WR_FWD_EN
        fwd1       = wr_col_hit && (wr_col_idx == idx1);
        fwd2       = wr_v_hit && (wr_v_idx == idx2);
`else
        fwd1       = 1'b0;
        fwd2       = 1'b0;
`endif
        word1      = !hit1 ? SENTINEL : (fwd1 ? wr_data : col_mem[idx1]);
        word2      = !hit2 ? SENTINEL : (fwd2 ? wr_data : v_mem[idx2]);
    end

    always_comb begin
        col_base_d = cfg_load ? col_base_in : col_base_q;
        v_base_d   = cfg_load ? v_base_in : v_base_q;
        oor_err_d  = oor_err_q
                   | (RD && !(hit1 && hit2))
                   | (WR && !(wr_col_hit || wr_v_hit));
        rd_count_d = (RD && (rd_count_q != 16'hFFFF)) ? rd_count_q + 16'd1 : rd_count_q;

        // Each stage's data moves only alongside a valid bit, so the last stage holds the most recent response.
        pv_d  = pv_q;
        pd1_d = pd1_q;
        pd2_d = pd2_q;
        pv_d[0] = RD;
        if (RD) begin
            pd1_d[0] = word1;
            pd2_d[0] = word2;
        end
        for (int i = 1; i < RD_LAT; i++) begin
            pv_d[i] = pv_q[i-1];
            if (pv_q[i-1]) begin
                pd1_d[i] = pd1_q[i-1];
                pd2_d[i] = pd2_q[i-1];
            end
        end
    end

    // Memory contents survive reset; only the pipeline and status are cleared.
    always_ff @(posedge Clk) begin
        if (wr_col_hit) col_mem[wr_col_idx] <= wr_data;
        if (wr_v_hit)   v_mem[wr_v_idx]     <= wr_data;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            col_base_q <= '0;
            v_base_q   <= '0;
            oor_err_q  <= 1'b0;
            rd_count_q <= '0;
            pv_q       <= '0;
            pd1_q      <= '0;
            pd2_q      <= '0;
        end else begin
            col_base_q <= col_base_d;
            v_base_q   <= v_base_d;
            oor_err_q  <= oor_err_d;
            rd_count_q <= rd_count_d;
            pv_q       <= pv_d;
            pd1_q      <= pd1_d;
            pd2_q      <= pd2_d;
        end
    end

    assign rdata1   = pd1_q[RD_LAT-1];
    assign rdata2   = pd2_q[RD_LAT-1];
    assign rvalid   = pv_q[RD_LAT-1];
    assign oor_err  = oor_err_q;
    assign rd_count = rd_count_q;

endmodule

// File: tb/tb_hht_mem_responder.sv
// Scoreboard bench: two responders (latency 1 and 3) share stimulus; a window-level reference model predicts responses.
module tb_hht_mem_responder;

    localparam logic [31:0] SENT = 32'd99999;

    logic        Clk = 1'b0;
    logic        Rst, cfg_load, WR, wr_sel, RD;
    logic [31:0] col_base_in, v_base_in, wr_addr, wr_data, addr1, addr2;

    logic [31:0] a_rdata1, a_rdata2, b_rdata1, b_rdata2;
    logic        a_rvalid, a_oor, b_rvalid, b_oor;
    logic [15:0] a_cnt, b_cnt;

    always #5 Clk = ~Clk;

    hht_mem_responder #(.RD_LAT(1)) u_lat1 (
        .Clk(Clk), .Rst(Rst), .cfg_load(cfg_load), .col_base_in(col_base_in), .v_base_in(v_base_in),
        .WR(WR), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data), .RD(RD), .addr1(addr1), .addr2(addr2),
        .rdata1(a_rdata1), .rdata2(a_rdata2), .rvalid(a_rvalid), .oor_err(a_oor), .rd_count(a_cnt));

    hht_mem_responder #(.RD_LAT(3)) u_lat3 (
        .Clk(Clk), .Rst(Rst), .cfg_load(cfg_load), .col_base_in(col_base_in), .v_base_in(v_base_in),
        .WR(WR), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data), .RD(RD), .addr1(addr1), .addr2(addr2),
        .rdata1(b_rdata1), .rdata2(b_rdata2), .rvalid(b_rvalid), .oor_err(b_oor), .rd_count(b_cnt));

    typedef struct {
        logic [31:0] d1;
        logic [31:0] d2;
        int          due;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   mon_en = 1'b0;

    logic [31:0] m_col [128];
    logic [31:0] m_v   [16];
    logic [31:0] m_cb, m_vb;
    logic        m_oor;
    int          m_cnt;
    logic [31:0] last_a1, last_a2, last_b1, last_b2;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h) at cycle %0d", name, act, act, exp, exp, cyc);
        end
    endtask

    function automatic bit inwin(input logic [31:0] a, input logic [31:0] base, input int depth);
        longint la, lb;
        la = longint'({32'd0, a});
        lb = longint'({32'd0, base});
        return (la >= lb) && (la <= lb + depth - 1);
    endfunction

    always @(negedge Clk) begin
        if (mon_en) begin
            if (a_rvalid) begin
                if (qa.size() == 0) chk("lat1_unexpected_rvalid", 32'd1, 32'd0);
                else begin
                    exp_t e;
                    e = qa.pop_front();
                    chk("lat1_rdata1", a_rdata1, e.d1);
                    chk("lat1_rdata2", a_rdata2, e.d2);
                    chk("lat1_latency", cyc, e.due);
                    $display("lat1 rsp cyc=%0d rdata1=%0d rdata2=%0d", cyc, a_rdata1, a_rdata2);
                    last_a1 = e.d1;
                    last_a2 = e.d2;
                end
            end else begin
                chk("lat1_hold1", a_rdata1, last_a1);
                chk("lat1_hold2", a_rdata2, last_a2);
            end
            if (b_rvalid) begin
                if (qb.size() == 0) chk("lat3_unexpected_rvalid", 32'd1, 32'd0);
                else begin
                    exp_t e;
                    e = qb.pop_front();
                    chk("lat3_rdata1", b_rdata1, e.d1);
                    chk("lat3_rdata2", b_rdata2, e.d2);
                    chk("lat3_latency", cyc, e.due);
                    $display("lat3 rsp cyc=%0d rdata1=%0d rdata2=%0d", cyc, b_rdata1, b_rdata2);
                    last_b1 = e.d1;
                    last_b2 = e.d2;
                end
            end else begin
                chk("lat3_hold1", b_rdata1, last_b1);
                chk("lat3_hold2", b_rdata2, last_b2);
            end
        end
    end

    // One clock of stimulus: predict from the model state before the edge, then advance the model.
    task automatic step(input logic rd, input logic [31:0] a1, input logic [31:0] a2,
                        input logic wr, input logic sel, input logic [31:0] wa, input logic [31:0] wd,
                        input logic cl, input logic [31:0] cb, input logic [31:0] vb);
        logic [31:0] off;
        bit          h1, h2, wh;
        exp_t        e;
        RD = rd; addr1 = a1; addr2 = a2;
        WR = wr; wr_sel = sel; wr_addr = wa; wr_data = wd;
        cfg_load = cl; col_base_in = cb; v_base_in = vb;
        h1 = inwin(a1, m_cb, 128);
        h2 = inwin(a2, m_vb, 16);
        wh = sel ? inwin(wa, m_vb, 16) : inwin(wa, m_cb, 128);
        if (rd) begin
            off  = a1 - m_cb;
            e.d1 = h1 ? m_col[off[6:0]] : SENT;
            off  = a2 - m_vb;
            e.d2 = h2 ? m_v[off[3:0]] : SENT;
`ifdef HHT_MEM_WR_FWD_EN
            if (h1 && wr && !sel && wh && wa == a1) e.d1 = wd;
            if (h2 && wr &&  sel && wh && wa == a2) e.d2 = wd;
`endif
            e.due = cyc + 1;
            qa.push_back(e);
            e.due = cyc + 3;
            qb.push_back(e);
            if (!h1 || !h2) m_oor = 1'b1;
            if (m_cnt < 65535) m_cnt++;
        end
        if (wr) begin
            if (!wh) m_oor = 1'b1;
            else if (sel) begin
                off = wa - m_vb;
                m_v[off[3:0]] = wd;
            end else begin
                off = wa - m_cb;
                m_col[off[6:0]] = wd;
            end
        end
        if (cl) begin
            m_cb = cb;
            m_vb = vb;
        end
        @(posedge Clk);
        #1;
        chk("lat1_oor_err", {31'd0, a_oor}, {31'd0, m_oor});
        chk("lat3_oor_err", {31'd0, b_oor}, {31'd0, m_oor});
        chk("lat1_rd_count", {16'd0, a_cnt}, m_cnt);
        chk("lat3_rd_count", {16'd0, b_cnt}, m_cnt);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic cfg(input logic [31:0] cb, input logic [31:0] vb);
        step(0, 0, 0, 0, 0, 0, 0, 1, cb, vb);
    endtask

    task automatic rd(input logic [31:0] a1, input logic [31:0] a2);
        step(1, a1, a2, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        Rst = 1; RD = 0; WR = 0; cfg_load = 0;
        @(posedge Clk);
        #1;
        qa.delete();
        qb.delete();
        m_oor = 0; m_cnt = 0; m_cb = 0; m_vb = 0;
        last_a1 = 0; last_a2 = 0; last_b1 = 0; last_b2 = 0;
        mon_en = 1'b1;
        @(posedge Clk);
        #1;
        Rst = 0;
        chk("rst_lat1_rvalid", {31'd0, a_rvalid}, 32'd0);
        chk("rst_lat3_rvalid", {31'd0, b_rvalid}, 32'd0);
        chk("rst_lat1_rdata1", a_rdata1, 32'd0);
        chk("rst_lat3_rdata2", b_rdata2, 32'd0);
        chk("rst_lat1_oor", {31'd0, a_oor}, 32'd0);
        chk("rst_lat3_count", {16'd0, b_cnt}, 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        Rst = 1; cfg_load = 0; WR = 0; wr_sel = 0; RD = 0;
        col_base_in = 0; v_base_in = 0; wr_addr = 0; wr_data = 0; addr1 = 0; addr2 = 0;
        do_reset();

        // Preload both windows, then the reference words 6@180, 14@181, 46@2.
        cfg(180, 2);
        for (int i = 0; i < 128; i++) step(0, 0, 0, 1, 0, 180 + i, $urandom, 0, 0, 0);
        for (int i = 0; i < 16; i++)  step(0, 0, 0, 1, 1, 2 + i, $urandom, 0, 0, 0);
        step(0, 0, 0, 1, 0, 180, 6, 0, 0, 0);
        step(0, 0, 0, 1, 0, 181, 14, 0, 0, 0);
        step(0, 0, 0, 1, 1, 2, 46, 0, 0, 0);
        rd(180, 2);
        idle(4);

        // Streamed reads across the whole column window from a cleared counter.
        do_reset();
        cfg(180, 2);
        for (int i = 0; i < 128; i++) rd(180 + i, 2 + (i % 16));
        idle(4);
        chk("stream_rd_count_lat1", {16'd0, a_cnt}, 32'd128);
        chk("stream_rd_count_lat3", {16'd0, b_cnt}, 32'd128);

        // Out-of-window reads on both ports, then sticky flag across good reads.
        rd(179, 18);
        rd(180, 2);
        rd(181, 17);
        idle(4);
        chk("oor_sticky", {31'd0, a_oor}, 32'd1);

        // Same-cycle write and read of one word, then a plain read of it.
        step(1, 181, 2, 1, 0, 181, 7, 0, 0, 0);
        rd(181, 2);
        step(1, 180, 3, 1, 1, 3, 55, 0, 0, 0);
        rd(180, 3);
        idle(4);

        // Reset one cycle after a read: the latency-3 response is dropped.
        rd(180, 2);
        do_reset();
        cfg(180, 2);
        rd(180, 2);
        idle(4);

        // Column window at the top of the address space must not wrap to low addresses.
        cfg(32'hFFFF_FFF0, 32'hFFFF_FFFA);
        rd(32'h0000_0005, 32'hFFFF_FFFA);
        rd(32'hFFFF_FFF0, 32'hFFFF_FFFF);
        rd(32'h0000_006F, 32'h0000_0002);
        rd(32'hFFFF_FFFF, 32'hFFFF_FFF9);
        idle(4);

        for (int n = 0; n < 400; n++) begin
            logic [31:0] cb, vb, a1, a2, wa;
            logic        cl, wr, sel, r;
            cl = ($urandom_range(0, 19) == 0);
            case ($urandom_range(0, 3))
                0: cb = 32'd180;
                1: cb = 32'd0;
                2: cb = 32'hFFFF_FFF0;
                default: cb = $urandom;
            endcase
            vb  = ($urandom_range(0, 1) == 0) ? 32'd2 : 32'hFFFF_FFFA;
            a1  = m_cb + $urandom_range(0, 131) - 32'd2;
            a2  = m_vb + $urandom_range(0, 19) - 32'd2;
            r   = ($urandom_range(0, 3) != 0);
            wr  = ($urandom_range(0, 3) == 0);
            sel = $urandom_range(0, 1);
            wa  = sel ? (m_vb + $urandom_range(0, 19) - 32'd2) : (m_cb + $urandom_range(0, 131) - 32'd2);
            if ($urandom_range(0, 2) == 0) wa = sel ? a2 : a1;
            step(r, a1, a2, wr, sel, wa, $urandom, cl, cb, vb);
        end

        idle(6);
        chk("drain_lat1", qa.size(), 32'd0);
        chk("drain_lat3", qb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
